// File: rtl/seg7_decoder.sv
// seg7_decoder: scans eight active-low seven-segment patterns until a stable snapshot is seen, then decodes it to BCD
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin one decode operation (honoured only when idle)
//   hex0..hex7           seven-segment patterns, active-low, bit0=a .. bit6=g
//   busy, done           operation in progress / one-cycle completion pulse
//   digit0..digit7       decoded BCD per pattern (4'hF when illegal)
//   err_mask             bit k set when hexk was illegal in the accepted snapshot
//   valid, timeout       snapshot fully legal and stable / gave up after MAX_SCANS
module seg7_decoder #(
    parameter int STABLE_SCANS = 2,
    parameter int MAX_SCANS    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] hex0,
    input  logic [6:0] hex1,
    input  logic [6:0] hex2,
    input  logic [6:0] hex3,
    input  logic [6:0] hex4,
    input  logic [6:0] hex5,
    input  logic [6:0] hex6,
    input  logic [6:0] hex7,
    output logic       busy,
    output logic       done,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic [3:0] digit5,
    output logic [3:0] digit6,
    output logic [3:0] digit7,
    output logic [7:0] err_mask,
    output logic       valid,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, SCAN, CHECK, DONE} state_t;

    localparam logic [3:0] STABLE_N = 4'(STABLE_SCANS);
    localparam logic [3:0] MAX_N    = 4'(MAX_SCANS);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       scan_cnt_q, scan_cnt_d;
    logic [3:0]       stable_cnt_q, stable_cnt_d;
    logic [7:0][6:0]  cur_q, cur_d;
    logic [7:0][6:0]  prev_q, prev_d;
    logic [7:0][3:0]  digit_q, digit_d;
    logic [7:0]       err_q, err_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0][6:0]  hex;
    logic [7:0][3:0]  dec;
    logic [7:0]       bad;

    function automatic logic [3:0] seg_dec(input logic [6:0] p);
        case (p)
            7'h40:   seg_dec = 4'd0;
            7'h79:   seg_dec = 4'd1;
            7'h24:   seg_dec = 4'd2;
            7'h30:   seg_dec = 4'd3;
            7'h19:   seg_dec = 4'd4;
            7'h12:   seg_dec = 4'd5;
            7'h02:   seg_dec = 4'd6;
            7'h78:   seg_dec = 4'd7;
            7'h00:   seg_dec = 4'd8;
            7'h10:   seg_dec = 4'd9;
            default: seg_dec = 4'hF;
        endcase
    endfunction

    assign hex = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            dec[i] = seg_dec(cur_q[i]);
            bad[i] = dec[i] == 4'hF;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        scan_cnt_d   = scan_cnt_q;
        stable_cnt_d = stable_cnt_q;
        cur_d        = cur_q;
        prev_d       = prev_q;
        digit_d      = digit_q;
        err_d        = err_q;
        valid_d      = valid_q;
        timeout_d    = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SCAN;
                    idx_d        = '0;
                    scan_cnt_d   = '0;
                    stable_cnt_d = '0;
                end
            end
            SCAN: begin
                cur_d[idx_q] = hex[idx_q];
                idx_d        = idx_q + 3'd1;
                state_d      = (idx_q == 3'd7) ? CHECK : SCAN;
            end
            CHECK: begin
                scan_cnt_d   = scan_cnt_q + 4'd1;
                // A first scan has nothing to compare against, so it always restarts the run
                stable_cnt_d = (scan_cnt_q == 4'd0 || cur_q != prev_q) ? 4'd1 : stable_cnt_q + 4'd1;
                prev_d       = cur_q;
                idx_d        = '0;
                if (stable_cnt_d == STABLE_N || scan_cnt_d == MAX_N) begin
                    state_d   = DONE;
                    timeout_d = stable_cnt_d != STABLE_N;
                    digit_d   = dec;
                    err_d     = bad;
                    valid_d   = (bad == 8'h00) && (stable_cnt_d == STABLE_N);
                end else begin
                    state_d = SCAN;
                end
            end
            DONE: state_d = IDLE;
        endcase
        busy_d = (state_d == SCAN) || (state_d == CHECK);
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            scan_cnt_q   <= '0;
            stable_cnt_q <= '0;
            cur_q        <= '0;
            prev_q       <= '0;
            digit_q      <= '0;
            err_q        <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            scan_cnt_q   <= scan_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            cur_q        <= cur_d;
            prev_q       <= prev_d;
            digit_q      <= digit_d;
            err_q        <= err_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign digit0   = digit_q[0];
    assign digit1   = digit_q[1];
    assign digit2   = digit_q[2];
    assign digit3   = digit_q[3];
    assign digit4   = digit_q[4];
    assign digit5   = digit_q[5];
    assign digit6   = digit_q[6];
    assign digit7   = digit_q[7];
    assign err_mask = err_q;
    assign valid    = valid_q;
    assign timeout  = timeout_q;
endmodule

// File: tb/tb_seg7_decoder.sv
// tb_seg7_decoder: directed self-checking bench for seg7_decoder
module tb_seg7_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic       busy, done, valid, timeout;
    logic [3:0] digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7;
    logic [7:0] err_mask;
    int         tests = 0;
    int         fails = 0;

    localparam logic [7:0][6:0] BASE   = {7'h02, 7'h12, 7'h19, 7'h79, 7'h24, 7'h19, 7'h30, 7'h12};
    localparam logic [31:0]     BASE_D = {4'd6, 4'd5, 4'd4, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5};

    seg7_decoder dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7),
        .busy(busy), .done(done),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .digit4(digit4), .digit5(digit5), .digit6(digit6), .digit7(digit7),
        .err_mask(err_mask), .valid(valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    wire [31:0] digits = {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0};

    task automatic set_hex(input logic [7:0][6:0] v);
        {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0} = v;
    endtask

    // Pulses start for the accepting edge (edge 0) and returns the edge after which done is seen.
    // mode 1: hex0 alternates 0x40/0x79 per scan; mode 2: hex2 switches to 0x30 after edge 4.
    task automatic run_op(input int mode, output int edges);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 0;
        while (edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
            if (mode == 1) hex0 = ((edges / 9) % 2 == 1) ? 7'h79 : 7'h40;
            if (mode == 2 && edges == 4) hex2 = 7'h30;
            if (done) break;
        end
    endtask

    task automatic check_result(input string name, input int edges, input int exp_edges,
                                input logic [31:0] exp_d, input logic [7:0] exp_err,
                                input logic exp_valid, input logic exp_to);
        tests++;
        if (edges !== exp_edges) begin fails++; $display("FAIL %s done_edge got %0d want %0d", name, edges, exp_edges); end
        tests++;
        if (digits !== exp_d) begin fails++; $display("FAIL %s digits got %h want %h", name, digits, exp_d); end
        tests++;
        if ({err_mask, valid, timeout} !== {exp_err, exp_valid, exp_to}) begin
            fails++;
            $display("FAIL %s err/valid/timeout got %h/%b/%b want %h/%b/%b", name, err_mask, valid, timeout, exp_err, exp_valid, exp_to);
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({busy, done, valid, timeout, err_mask, digits} !== '0) begin
            fails++;
            $display("FAIL reset outputs got busy=%b done=%b valid=%b to=%b err=%h d=%h want all 0", busy, done, valid, timeout, err_mask, digits);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_legal();
        int e;
        set_hex(BASE);
        run_op(0, e);
        check_result("legal", e, 18, BASE_D, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        tests++;
        if ({done, busy} !== 2'b00) begin fails++; $display("FAIL legal done_pulse got done=%b busy=%b want 0/0", done, busy); end
    endtask

    task automatic test_illegal();
        int e;
        set_hex(BASE);
        hex3 = 7'h7F;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if ({busy, digits, valid} !== {1'b1, BASE_D, 1'b1}) begin
            fails++;
            $display("FAIL hold_while_busy got busy=%b d=%h valid=%b want 1/%h/1", busy, digits, valid, BASE_D);
        end
        e = 5;
        while (e < 200 && !done) begin @(posedge clk); e++; #1; end
        check_result("blank_hex3", e, 18, {BASE_D[31:16], 4'hF, BASE_D[11:0]}, 8'h08, 1'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_patterns();
        int e;
        set_hex({7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40});
        run_op(0, e);
        check_result("digits0to7", e, 18, 32'h76543210, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        set_hex({7'h40, 7'h40, 7'h40, 7'h40, 7'h41, 7'h7F, 7'h10, 7'h00});
        run_op(0, e);
        check_result("digits89_bad", e, 18, 32'h0000FF98, 8'h0C, 1'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        int e;
        set_hex(BASE);
        hex0 = 7'h40;
        run_op(1, e);
        check_result("timeout", e, 72, {BASE_D[31:4], 4'd1}, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_change();
        int e;
        set_hex(BASE);
        run_op(2, e);
        check_result("restabilise", e, 27, {BASE_D[31:12], 4'd3, BASE_D[7:0]}, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int e;
        int seen = 0;
        set_hex(BASE);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, valid, timeout, err_mask, digits} !== '0) begin
            fails++;
            $display("FAIL mid_reset outputs got busy=%b done=%b valid=%b to=%b err=%h d=%h want all 0", busy, done, valid, timeout, err_mask, digits);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (25) begin @(posedge clk); #1; if (done || busy) seen++; end
        tests++;
        if (seen !== 0) begin fails++; $display("FAIL mid_reset activity got %0d busy/done cycles want 0", seen); end
        run_op(0, e);
        check_result("after_reset", e, 18, BASE_D, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int d18 = 0;
        int d38 = 0;
        int other = 0;
        int busy_in_done = 0;
        set_hex(BASE);
        start = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e == 39) start = 1'b0;
            if (done && busy) busy_in_done++;
            if (done) begin
                if (e == 18) d18++;
                else if (e == 38) d38++;
                else other++;
            end
        end
        tests++;
        if ({d18, d38, other} !== {32'd1, 32'd1, 32'd0}) begin
            fails++;
            $display("FAIL held_start done pulses got at18=%0d at38=%0d other=%0d want 1/1/0", d18, d38, other);
        end
        tests++;
        if (busy_in_done !== 0) begin fails++; $display("FAIL held_start busy_in_done got %0d want 0", busy_in_done); end
        @(posedge clk);
        #1;
        tests++;
        if ({busy, done} !== 2'b00) begin fails++; $display("FAIL held_start idle got busy=%b done=%b want 0/0", busy, done); end
    endtask

    initial begin
        set_hex(BASE);
        test_reset();
        test_legal();
        test_illegal();
        test_all_patterns();
        test_timeout();
        test_change();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
